// File: rtl/match_pe_scoreboard.sv
// Match PE initiator: tracks match jobs in a small scoreboard, issues chunked compare requests and returns lengths in order.
// Optional sticky protocol checker (o_err) when MATCH_SCOREBOARD_CHECK_EN is defined.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef MATCH_PE_WIDTH
`define MATCH_PE_WIDTH 16
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 5
`endif

module match_pe_scoreboard #(
  parameter int SCOREBOARD_ENTRY_INDEX = 2,
  parameter int PE_LATENCY             = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_job_valid,
  output logic                              o_job_ready,
  input  logic [`ADDR_WIDTH-1:0]            i_job_head_addr,
  input  logic [`ADDR_WIDTH-1:0]            i_job_history_addr,
  output logic                              o_pe_valid,
  output logic [SCOREBOARD_ENTRY_INDEX-1:0] o_pe_idx,
  output logic                              o_pe_last,
  output logic [`ADDR_WIDTH-1:0]            o_pe_head_addr,
  output logic [`ADDR_WIDTH-1:0]            o_pe_history_addr,
  input  logic                              i_pe_valid,
  input  logic [SCOREBOARD_ENTRY_INDEX-1:0] i_pe_idx,
  input  logic                              i_pe_last,
  input  logic [`MAX_MATCH_LEN_LOG2:0]      i_pe_match_len,
  output logic                              o_res_valid,
  input  logic                              i_res_ready,
  output logic [`MAX_MATCH_LEN_LOG2:0]      o_res_match_len
`ifdef MATCH_SCOREBOARD_CHECK_EN
  ,
  output logic                              o_err
`endif
);

  localparam int SI = SCOREBOARD_ENTRY_INDEX;
  localparam int N  = 1 << SI;
  localparam int LW = `MAX_MATCH_LEN_LOG2 + 1;
  localparam int AW = `ADDR_WIDTH;
  localparam logic [LW-1:0] MAX_LEN = LW'(1 << `MAX_MATCH_LEN_LOG2);
  localparam logic [LW-1:0] PE_W    = LW'(`MATCH_PE_WIDTH);
  localparam logic [AW-1:0] ADDR_W  = AW'(`MATCH_PE_WIDTH);

  typedef enum logic [1:0] {S_FREE, S_ISSUE, S_WAIT, S_DONE} entry_state_t;

  entry_state_t  state_q [N];
  logic [AW-1:0] head_q  [N];
  logic [AW-1:0] hist_q  [N];
  logic [LW-1:0] acc_q   [N];

  logic [SI-1:0] alloc_ptr;
  logic [SI-1:0] ret_ptr;
  logic [SI-1:0] rr_ptr;

  logic          issue_found;
  logic [SI-1:0] issue_idx;
  logic          issue_last;
  logic          res_hit;
  logic          rearm;
  logic [LW:0]   sum_wide;
  logic [LW-1:0] sat_sum;
  logic          job_accept;
  logic          res_accept;

  assign o_job_ready     = rst_n && (state_q[alloc_ptr] == S_FREE);
  assign o_res_valid     = rst_n && (state_q[ret_ptr] == S_DONE);
  assign o_res_match_len = acc_q[ret_ptr];
  assign job_accept      = i_job_valid && o_job_ready;
  assign res_accept      = o_res_valid && i_res_ready;

  // Round-robin pick of the first ISSUE entry at or after rr_ptr.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = rr_ptr;
    for (int k = 0; k < N; k++) begin
      if (!issue_found && state_q[rr_ptr + SI'(k)] == S_ISSUE) begin
        issue_found = 1'b1;
        issue_idx   = rr_ptr + SI'(k);
      end
    end
  end

  always_comb begin
    issue_last = ({1'b0, acc_q[issue_idx]} + {1'b0, PE_W}) >= {1'b0, MAX_LEN};
    res_hit    = i_pe_valid && (state_q[i_pe_idx] == S_WAIT);
    rearm      = (i_pe_match_len == PE_W) && !i_pe_last;
    sum_wide   = {1'b0, acc_q[i_pe_idx]} + {1'b0, i_pe_match_len};
    sat_sum    = (sum_wide > {1'b0, MAX_LEN}) ? MAX_LEN : sum_wide[LW-1:0];
  end

  // Writeback, issue, allocate and retire always touch entries in distinct states, so they never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) state_q[k] <= S_FREE;
      alloc_ptr  <= '0;
      ret_ptr    <= '0;
      rr_ptr     <= '0;
      o_pe_valid <= 1'b0;
    end else begin
      if (res_hit) begin
        acc_q[i_pe_idx] <= sat_sum;
        if (rearm) begin
          state_q[i_pe_idx] <= S_ISSUE;
          head_q[i_pe_idx]  <= head_q[i_pe_idx] + ADDR_W;
          hist_q[i_pe_idx]  <= hist_q[i_pe_idx] + ADDR_W;
        end else begin
          state_q[i_pe_idx] <= S_DONE;
        end
      end
      o_pe_valid <= issue_found;
      if (issue_found) begin
        state_q[issue_idx] <= S_WAIT;
        o_pe_idx           <= issue_idx;
        o_pe_last          <= issue_last;
        o_pe_head_addr     <= head_q[issue_idx];
        o_pe_history_addr  <= hist_q[issue_idx];
        rr_ptr             <= issue_idx + SI'(1);
      end
      if (job_accept) begin
        state_q[alloc_ptr] <= S_ISSUE;
        acc_q[alloc_ptr]   <= '0;
        head_q[alloc_ptr]  <= i_job_head_addr;
        hist_q[alloc_ptr]  <= i_job_history_addr;
        alloc_ptr          <= alloc_ptr + SI'(1);
      end
      if (res_accept) begin
        state_q[ret_ptr] <= S_FREE;
        ret_ptr          <= ret_ptr + SI'(1);
      end
    end
  end

`ifdef MATCH_SCOREBOARD_CHECK_EN
  logic [7:0] ts_q      [N];
  logic       last_sent [N];

  // Per-entry age since issue; a result must land exactly PE_LATENCY cycles after its request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_err <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (state_q[k] == S_WAIT && ts_q[k] != 8'hFF) ts_q[k] <= ts_q[k] + 8'd1;
      end
      if (issue_found) begin
        ts_q[issue_idx]      <= 8'd0;
        last_sent[issue_idx] <= issue_last;
      end
      if (i_pe_valid) begin
        if (state_q[i_pe_idx] != S_WAIT) begin
          o_err <= 1'b1;
          $display("match_pe_scoreboard: result for idle entry t=%0t idx=%0d", $time, i_pe_idx);
        end else begin
          if (i_pe_last != last_sent[i_pe_idx]) begin
            o_err <= 1'b1;
            $display("match_pe_scoreboard: last flag error t=%0t idx=%0d", $time, i_pe_idx);
          end
          if (ts_q[i_pe_idx] != 8'(PE_LATENCY)) begin
            o_err <= 1'b1;
            $display("match_pe_scoreboard: latency error t=%0t idx=%0d", $time, i_pe_idx);
          end
        end
      end
    end
  end
`else
  logic unused_latency;
  assign unused_latency = |32'(PE_LATENCY);
`endif

endmodule

// File: tb/tb_match_pe_scoreboard.sv
// Self-checking bench for match_pe_scoreboard: latency-6 PE model plus an in-order result scoreboard.
`timescale 1ns/1ps
module tb_match_pe_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_job_valid;
  logic        o_job_ready;
  logic [31:0] i_job_head_addr;
  logic [31:0] i_job_history_addr;
  logic        o_pe_valid;
  logic [1:0]  o_pe_idx;
  logic        o_pe_last;
  logic [31:0] o_pe_head_addr;
  logic [31:0] o_pe_history_addr;
  logic        i_pe_valid;
  logic [1:0]  i_pe_idx;
  logic        i_pe_last;
  logic [5:0]  i_pe_match_len;
  logic        o_res_valid;
  logic        i_res_ready;
  logic [5:0]  o_res_match_len;
`ifdef MATCH_SCOREBOARD_CHECK_EN
  logic        err;
`endif

  match_pe_scoreboard #(.SCOREBOARD_ENTRY_INDEX(2), .PE_LATENCY(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_job_valid(i_job_valid),
    .o_job_ready(o_job_ready),
    .i_job_head_addr(i_job_head_addr),
    .i_job_history_addr(i_job_history_addr),
    .o_pe_valid(o_pe_valid),
    .o_pe_idx(o_pe_idx),
    .o_pe_last(o_pe_last),
    .o_pe_head_addr(o_pe_head_addr),
    .o_pe_history_addr(o_pe_history_addr),
    .i_pe_valid(i_pe_valid),
    .i_pe_idx(i_pe_idx),
    .i_pe_last(i_pe_last),
    .i_pe_match_len(i_pe_match_len),
    .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready),
    .o_res_match_len(o_res_match_len)
`ifdef MATCH_SCOREBOARD_CHECK_EN
    ,
    .o_err(err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Bench-side view of each scoreboard entry.
  logic [31:0] m_head [4];
  logic [31:0] m_hist [4];
  int          m_chunk[4];
  int          m_acc  [4];
  int          m_r0   [4];
  int          m_r1   [4];
  int          m_alloc = 0;
  int          exp_q[$];

  typedef struct {int due; int idx; logic last; int len;} pend_t;
  pend_t pend_q[$];

  bit inject = 1'b0;
  int last_retire_cyc = -1;
  int accept_cyc = -1;
  int req_cyc = -1;
  int resv_cyc = -1;

  function automatic int exp_total(input int r0, input int r1);
    int acc;
    acc = (r0 > 32) ? 32 : r0;
    if (r0 == 16) begin
      acc = acc + r1;
      if (acc > 32) acc = 32;
    end
    return acc;
  endfunction

  // PE model: checks each request and echoes a result exactly 6 cycles later.
  initial begin
    i_pe_valid = 1'b0; i_pe_idx = '0; i_pe_last = 1'b0; i_pe_match_len = '0;
    forever begin
      @(negedge clk);
      i_pe_valid = 1'b0;
      if (rst_n === 1'b1 && o_pe_valid === 1'b1) begin
        int i, c, len;
        pend_t p;
        i = int'(o_pe_idx);
        c = m_chunk[i];
        req_cyc = cyc;
        check_output("req_extra_chunk", 64'(c >= 2), 0);
        check_output("req_head", o_pe_head_addr, m_head[i] + 32'(16 * c));
        check_output("req_hist", o_pe_history_addr, m_hist[i] + 32'(16 * c));
        check_output("req_last", o_pe_last, 64'(m_acc[i] + 16 >= 32));
        len = (c == 0) ? m_r0[i] : m_r1[i];
        p.due = cyc + 6; p.idx = i; p.last = o_pe_last; p.len = len;
        pend_q.push_back(p);
        m_acc[i] = (m_acc[i] + len > 32) ? 32 : m_acc[i] + len;
        m_chunk[i] = c + 1;
      end
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        pend_t p;
        p = pend_q.pop_front();
        i_pe_valid = 1'b1; i_pe_idx = 2'(p.idx); i_pe_last = p.last; i_pe_match_len = 6'(p.len);
      end else if (inject) begin
        i_pe_valid = 1'b1; i_pe_idx = 2'd3; i_pe_last = 1'b0; i_pe_match_len = 6'd1;
        inject = 1'b0;
      end
    end
  end

  // Result monitor: every accepted result is compared against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && o_res_valid === 1'b1 && i_res_ready === 1'b1) begin
        last_retire_cyc = cyc;
        if (resv_cyc < 0) resv_cyc = cyc;
        if (exp_q.size() == 0) check_output("res_unexpected", 1, 0);
        else check_output("res_len", o_res_match_len, 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] head, input logic [31:0] hist, input int r0, input int r1);
    int n = 0;
    bit ok = 1'b0;
    i_job_valid = 1'b1; i_job_head_addr = head; i_job_history_addr = hist;
    while (!ok) begin
      @(negedge clk);
      if (o_job_ready === 1'b1) ok = 1'b1;
      else begin
        n++;
        if (n > 200) begin check_output("job_accept_timeout", 1, 0); break; end
      end
    end
    if (ok) begin
      m_head[m_alloc] = head; m_hist[m_alloc] = hist;
      m_chunk[m_alloc] = 0; m_acc[m_alloc] = 0;
      m_r0[m_alloc] = r0; m_r1[m_alloc] = r1;
      exp_q.push_back(exp_total(r0, r1));
      accept_cyc = cyc;
      m_alloc = (m_alloc + 1) % 4;
    end
    @(posedge clk); #1;
    i_job_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (exp_q.size() != 0 || pend_q.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > limit) begin
        check_output("drain_timeout", 64'(exp_q.size()), 0);
        exp_q.delete();
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e, n;
    logic [5:0] held;
    rst_n = 1'b0; i_job_valid = 1'b0; i_job_head_addr = '0; i_job_history_addr = '0; i_res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_job_ready", o_job_ready, 0);
    check_output("rst_res_valid", o_res_valid, 0);
    check_output("rst_pe_valid", o_pe_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("post_rst_job_ready", o_job_ready, 1);
    @(posedge clk); #1;

    $display("[TB] single short match");
    resv_cyc = -1;
    apply_stimulus(32'd0, 32'd100, 5, 0);
    wait_idle(100);
    check_output("issue_to_result_latency", 64'(resv_cyc - req_cyc), 7);

    $display("[TB] two full chunks, saturating at 32");
    e = m_alloc;
    apply_stimulus(32'd0, 32'd100, 16, 16);
    wait_idle(100);
    check_output("chunk_count", 64'(m_chunk[e]), 2);

    $display("[TB] fill scoreboard back-to-back");
    apply_stimulus(32'd200, 32'd300, 7, 0);
    apply_stimulus(32'd210, 32'd310, 16, 4);
    apply_stimulus(32'd220, 32'd320, 0, 0);
    apply_stimulus(32'd230, 32'd330, 16, 16);
    @(negedge clk);
    check_output("full_job_ready", o_job_ready, 0);
    @(posedge clk); #1;
    apply_stimulus(32'd240, 32'd340, 9, 0);
    check_output("realloc_after_retire", 64'(accept_cyc - last_retire_cyc), 1);
    wait_idle(200);

    $display("[TB] out-of-order completion, in-order return");
    apply_stimulus(32'd400, 32'd500, 16, 3);
    apply_stimulus(32'd410, 32'd510, 16, 6);
    apply_stimulus(32'd420, 32'd520, 16, 11);
    apply_stimulus(32'd430, 32'd530, 2, 0);
    wait_idle(200);

    $display("[TB] result backpressure");
    i_res_ready = 1'b0;
    apply_stimulus(32'd600, 32'd700, 16, 1);
    apply_stimulus(32'd610, 32'd710, 4, 0);
    apply_stimulus(32'd620, 32'd720, 16, 16);
    apply_stimulus(32'd630, 32'd730, 8, 0);
    repeat (40) @(posedge clk);
    #1;
    held = 6'(exp_q[0]);
    i_job_valid = 1'b1; i_job_head_addr = 32'd999; i_job_history_addr = 32'd999;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_output("hold_res_valid", o_res_valid, 1);
      check_output("hold_res_len", o_res_match_len, held);
      check_output("hold_job_ready", o_job_ready, 0);
    end
    @(posedge clk); #1;
    i_job_valid = 1'b0;
    i_res_ready = 1'b1;
    apply_stimulus(32'd800, 32'd900, 16, 16);
    n = 0;
    while (pend_q.size() == 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("inflight_before_reset", 64'(pend_q.size() != 0), 1);
    @(posedge clk); #1;

    $display("[TB] reset mid-run");
    rst_n = 1'b0;
    exp_q.delete();
    m_alloc = 0;
    @(posedge clk); #1;
    check_output("mid_rst_res_valid", o_res_valid, 0);
    check_output("mid_rst_pe_valid", o_pe_valid, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_output("stale_pe_valid", o_pe_valid, 0);
      check_output("stale_res_valid", o_res_valid, 0);
    end
    @(posedge clk); #1;
    apply_stimulus(32'd50, 32'd60, 10, 0);
    wait_idle(100);

`ifdef MATCH_SCOREBOARD_CHECK_EN
    $display("[TB] checker: result for idle entry");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("err_after_reset", err, 0);
    inject = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("err_set", err, 1);
    repeat (5) @(posedge clk);
    #1;
    check_output("err_sticky", err, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_output("err_cleared", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
